alu_ctrl_fsm: RTL and testbench
===============================

# alu_ctrl_fsm

Multi-cycle control sequencer for the 8-bit datapath. Accepts one 8-bit instruction per handshake, decodes it, and drives the ALU controls (ALUSRC, ALUOP, 2-bit function select), register-file addresses/enable, and data-memory strobes through a FETCH/DECODE/EXEC/MEM/WB state machine. It sits between instruction memory and the ALU/register-file datapath, acting as the producer of every ALU control input.

## Interface
- MEM_TIMEOUT, 15: max cycles in MEM waiting for MEM_ACK (1..255)
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset: synchronous, active-low
- INSTR_VALID  in  1  instruction present on INSTR
- INSTR  in  8  [7:6] opcode, [5:4] RS, [3:2] RT/RD, [1:0] RD or FN
- INSTR_READY  out  1  high in FETCH (gated with RST_N)
- MEM_ACK  in  1  data memory completes access (sampled only in MEM)
- ALUSRC  out  1  0 = IN1+IN2, 1 = unary op selected by ALU_FN
- ALUOP  out  1  high only in EXEC (ALU result valid)
- ALU_FN  out  2  00 pass, 01 +1, 10 -2, 11 -1
- RS_ADDR, RT_ADDR, RD_ADDR  out  2 each  register-file addresses
- WB_SEL  out  1  0 = write ALU result, 1 = write memory data
- REG_WE  out  1  register write strobe, one cycle
- MEM_RE, MEM_WE  out  1 each  data-memory strobes
- PC_INC  out  1  one-cycle pulse on instruction retire
- ERR  out  1  sticky: a memory access timed out
- RETIRED  out  8  retired-instruction counter, wraps 255->0

## Operation
- Opcodes: 00 ADD rd=IR[1:0], RF[rd]=RF[rs]+RF[rt]; 01 UNARY rd=IR[3:2], RF[rd]=f_FN(RF[rs]), FN=IR[1:0]; 10 LOAD RF[rt]=MEM[RF[rs]]; 11 STORE MEM[RF[rs]]=RF[rt].
- IR captured on INSTR_VALID & INSTR_READY edge; RS_ADDR=IR[5:4], RT_ADDR=IR[3:2] held from DECODE through WB.
- RD_ADDR: ADD -> IR[1:0]; UNARY -> IR[3:2]; LOAD -> IR[3:2]; STORE -> 0.
- ALUSRC: ADD 0, else 1. ALU_FN: UNARY -> IR[1:0]; LOAD/STORE -> 00 (address = RF[rs] passed through); ADD -> 00.
- States: FETCH -> DECODE on handshake; DECODE -> EXEC always; EXEC -> WB (ADD/UNARY) or MEM (LOAD/STORE); MEM -> WB on MEM_ACK or timeout; WB -> FETCH always.
- MEM: MEM_RE (LOAD) or MEM_WE (STORE) held high every MEM cycle; wait counter starts 0 on entry, increments per cycle without ack; ack at counter < MEM_TIMEOUT -> normal; counter reaching MEM_TIMEOUT -> ERR<=1, abort.
- WB: PC_INC=1, RETIRED+=1 always. REG_WE=1 for ADD, UNARY, acked LOAD; 0 for STORE and any aborted access. WB_SEL=1 only for LOAD.
- Outputs are Moore decodes of state, IR, abort flag; no combinational path from INSTR/INSTR_VALID/MEM_ACK to any output.
- ERR cleared only by reset.

## Timing
- Reset (RST_N low at edge): state=FETCH, IR=0, wait counter=0, ERR=0, RETIRED=0. While RST_N low: INSTR_READY=0, ALUOP=0, REG_WE=0, MEM_RE=0, MEM_WE=0, PC_INC=0, ALUSRC=0, ALU_FN=00, all addresses 0, WB_SEL=0.
- RST_N low in any state aborts the instruction: no REG_WE/MEM strobe/PC_INC on following cycles; first handshake possible in the cycle RST_N is high.
- ADD/UNARY: handshake at edge 0; DECODE cycle 1; EXEC cycle 2 (ALUOP=1); WB cycle 3 (REG_WE, PC_INC); INSTR_READY high cycle 4. Throughput 1 instruction per 4 cycles.
- LOAD/STORE with MEM_ACK after k MEM cycles (k>=1, ack in k-th cycle): WB in cycle 3+k; 4+k cycles total.
- MEM_ACK high in the cycle counter==MEM_TIMEOUT-1 is a valid ack; ack outside MEM ignored.
- INSTR_VALID outside FETCH ignored; INSTR may change freely.

## Test plan
- Reset then INSTR=8'b00_01_10_11 valid at cycle 0 -> EXEC cycle 2: ALUSRC=0, ALUOP=1, RS=1, RT=2; WB cycle 3: REG_WE=1, RD=3, PC_INC=1, RETIRED=1.
- UNARY 8'b01_10_01_10 -> EXEC ALUSRC=1, ALU_FN=10, RS=2; WB RD=1, REG_WE=1, WB_SEL=0.
- LOAD 8'b10_00_11_00, MEM_ACK after 3 MEM cycles -> MEM_RE high 3 cycles, WB cycle 6: REG_WE=1, WB_SEL=1, RD=3; INSTR_READY cycle 7.
- STORE with MEM_ACK never asserted, MEM_TIMEOUT=15 -> MEM_WE high 15 cycles, ERR=1, WB REG_WE=0, PC_INC=1; ERR stays 1 through next ADD.
- RST_N low during MEM of LOAD -> next cycle FETCH, no REG_WE/PC_INC, RETIRED and ERR =0; 256 ADDs -> RETIRED wraps to 0.
- INSTR_VALID held high during DECODE/EXEC/WB -> only one capture per FETCH; back-to-back ADDs retire every 4 cycles.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer producing every ALU, register-file and data-memory control.
// Latency: 4 cycles per ADD/UNARY, 4+k for LOAD/STORE acked in MEM cycle k; one instruction accepted per FETCH.
module alu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic       mem_ack,
  output logic       alusrc,
  output logic       aluop,
  output logic [1:0] alu_fn,
  output logic [1:0] rs_addr,
  output logic [1:0] rt_addr,
  output logic [1:0] rd_addr,
  output logic       wb_sel,
  output logic       reg_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       pc_inc,
  output logic       err,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_UNARY = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] ir;
  logic [7:0] wait_cnt;
  logic       aborted;
  logic [1:0] op;
  logic       mem_expired;

  assign op          = ir[7:6];
  assign mem_expired = (state == S_MEM) && !mem_ack && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      ir       <= 8'd0;
      wait_cnt <= 8'd0;
      aborted  <= 1'b0;
      err      <= 1'b0;
      retired  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && instr_valid) begin
        ir      <= instr;
        aborted <= 1'b0;
      end
      // Counter is zero on every MEM entry because it is cleared whenever MEM is not waiting.
      if (state == S_MEM && !mem_ack && !mem_expired)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
      if (mem_expired) begin
        aborted <= 1'b1;
        err     <= 1'b1;
      end
      if (state_nxt == S_WB)
        retired <= retired + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (instr_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = op[1] ? S_MEM : S_WB;
      S_MEM:    if (mem_ack || mem_expired) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Every control is forced low while reset is held, whatever state the register still shows.
  always_comb begin
    instr_ready = 1'b0;
    alusrc      = 1'b0;
    aluop       = 1'b0;
    alu_fn      = 2'b00;
    rs_addr     = 2'b00;
    rt_addr     = 2'b00;
    rd_addr     = 2'b00;
    wb_sel      = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_inc      = 1'b0;
    if (rst_n) begin
      if (state == S_FETCH) begin
        instr_ready = 1'b1;
      end else begin
        rs_addr = ir[5:4];
        rt_addr = ir[3:2];
        case (op)
          OP_ADD:  rd_addr = ir[1:0];
          OP_STORE: rd_addr = 2'b00;
          default: rd_addr = ir[3:2];
        endcase
        alusrc = (op != OP_ADD);
        alu_fn = (op == OP_UNARY) ? ir[1:0] : 2'b00;
        case (state)
          S_EXEC: aluop = 1'b1;
          S_MEM: begin
            mem_re = (op == OP_LOAD);
            mem_we = (op == OP_STORE);
          end
          S_WB: begin
            pc_inc = 1'b1;
            wb_sel = (op == OP_LOAD);
            reg_we = !op[1] || (op == OP_LOAD && !aborted);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized bench for alu_ctrl_fsm: each instruction is expanded by a per-instruction
// timeline model (phase list, retire count, sticky error) and every cycle's controls are compared.
module tb_alu_ctrl_fsm;
  localparam int T = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic       mem_ack;
  logic       alusrc, aluop, wb_sel, reg_we, mem_re, mem_we, pc_inc, err;
  logic [1:0] alu_fn, rs_addr, rt_addr, rd_addr;
  logic [7:0] retired;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_retired;
  logic       m_err;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .mem_ack(mem_ack), .alusrc(alusrc), .aluop(aluop),
    .alu_fn(alu_fn), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .wb_sel(wb_sel), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
    .pc_inc(pc_inc), .err(err), .retired(retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outside FETCH the instruction bus stays valid with junk, and ack toggles outside MEM.
  task automatic noise();
    instr_valid = 1'b1;
    instr       = 8'($urandom);
    mem_ack     = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, instr_ready, 0);
    chk({tag, "_aluop"}, aluop, 0);
    chk({tag, "_regwe"}, reg_we, 0);
    chk({tag, "_memre"}, mem_re, 0);
    chk({tag, "_memwe"}, mem_we, 0);
    chk({tag, "_pcinc"}, pc_inc, 0);
    chk({tag, "_alusrc"}, alusrc, 0);
    chk({tag, "_fn"}, alu_fn, 0);
    chk({tag, "_addr"}, {rs_addr, rt_addr, rd_addr}, 0);
    chk({tag, "_wbsel"}, wb_sel, 0);
  endtask

  // Runs one instruction from its FETCH cycle through WB; k = MEM cycle carrying the ack, 0 = never.
  task automatic run_instr(input logic [7:0] ins, input int k);
    logic [1:0] op, rs, rt, rd, fn;
    logic       acked, we;
    int         n;
    op    = ins[7:6];
    rs    = ins[5:4];
    rt    = ins[3:2];
    rd    = (op == 2'd0) ? ins[1:0] : (op == 2'd3) ? 2'd0 : ins[3:2];
    fn    = (op == 2'd1) ? ins[1:0] : 2'd0;
    acked = (k >= 1) && (k <= T);
    n     = acked ? k : T;
    we    = (op < 2'd2) || (op == 2'd2 && acked);

    chk("f_ready", instr_ready, 1);
    chk("f_pcinc", pc_inc, 0);
    chk("f_err", err, m_err);
    chk("f_retired", retired, m_retired);
    instr = ins; instr_valid = 1'b1; mem_ack = 1'($urandom_range(0, 1));
    tick();

    chk("d_ready", instr_ready, 0);
    chk("d_aluop", aluop, 0);
    chk("d_rs", rs_addr, rs);
    chk("d_rt", rt_addr, rt);
    chk("d_pcinc", pc_inc, 0);
    noise();
    tick();

    chk("e_aluop", aluop, 1);
    chk("e_alusrc", alusrc, op != 2'd0);
    chk("e_fn", alu_fn, fn);
    chk("e_rs", rs_addr, rs);
    chk("e_rt", rt_addr, rt);
    chk("e_rd", rd_addr, rd);
    chk("e_regwe", reg_we, 0);
    chk("e_mem", {mem_re, mem_we}, 0);
    noise();
    tick();

    if (op[1]) begin
      for (int i = 1; i <= n; i++) begin
        chk("m_re", mem_re, op == 2'd2);
        chk("m_we", mem_we, op == 2'd3);
        chk("m_aluop", aluop, 0);
        chk("m_wb", {reg_we, pc_inc}, 0);
        chk("m_rs", rs_addr, rs);
        instr = 8'($urandom);
        mem_ack = (i == k);
        tick();
      end
      if (!acked) m_err = 1'b1;
    end

    m_retired = m_retired + 8'd1;
    chk("w_pcinc", pc_inc, 1);
    chk("w_regwe", reg_we, we);
    chk("w_wbsel", wb_sel, op == 2'd2);
    chk("w_rd", rd_addr, rd);
    chk("w_rs", rs_addr, rs);
    chk("w_rt", rt_addr, rt);
    chk("w_retired", retired, m_retired);
    chk("w_err", err, m_err);
    chk("w_mem", {mem_re, mem_we, aluop, instr_ready}, 0);
    noise();
    tick();
  endtask

  initial begin
    m_retired = 8'd0;
    m_err     = 1'b0;
    rst_n = 1'b0;
    noise();
    tick();
    tick();
    chk_quiet("rst");
    chk("rst_err", err, 0);
    chk("rst_retired", retired, 0);

    rst_n = 1'b1; instr_valid = 1'b0; mem_ack = 1'b1;
    tick();
    chk("idle_ready", instr_ready, 1);
    chk("idle_pcinc", pc_inc, 0);

    run_instr(8'b00_01_10_11, 0);
    run_instr(8'b01_10_01_10, 0);
    run_instr(8'b10_00_11_00, 3);
    run_instr(8'b11_01_10_00, 0);
    run_instr(8'b00_11_00_01, 0);
    run_instr(8'b10_10_01_11, T);
    run_instr(8'b11_00_11_10, 1);
    for (int i = 0; i < 40; i++)
      run_instr(8'($urandom), $urandom_range(0, T));

    // Reset pulled in the middle of a LOAD's MEM phase.
    instr = 8'b10_00_11_00; instr_valid = 1'b1; mem_ack = 1'b0;
    tick();
    noise();
    tick();
    mem_ack = 1'b0; instr_valid = 1'b0;
    tick();
    chk("ab_memre1", mem_re, 1);
    tick();
    chk("ab_memre2", mem_re, 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("ab_low");
    tick();
    chk_quiet("ab_post");
    chk("ab_retired", retired, 0);
    chk("ab_err", err, 0);
    rst_n = 1'b1;
    #1;
    chk("ab_ready", instr_ready, 1);
    m_retired = 8'd0;
    m_err     = 1'b0;

    for (int i = 0; i < 256; i++)
      run_instr({2'b00, 6'($urandom)}, 0);
    chk("wrap_retired", retired, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
